// File: rtl/data_ram_responder.sv
// Wait-state data-memory responder: one load/store at a time, RAM_READY after WAIT_STATES+1 cycles.
// Define RAM_BYTE_WRITE_EN to add RAM_BYTE_STROBE and per-byte-lane store masking.
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    RAM_REQ,
  input  logic [ADDR_WIDTH-1:0]   RAM_ADDR,
  input  logic                    RAM_WRITE_ENABLE,
  input  logic [DATA_WIDTH-1:0]   RAM_WRITE_DATA,
`ifdef RAM_BYTE_WRITE_EN
  input  logic [DATA_WIDTH/8-1:0] RAM_BYTE_STROBE,
`endif
  output logic                    RAM_READY,
  output logic [DATA_WIDTH-1:0]   RAM_READ_DATA,
  output logic                    RAM_ERROR
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [LANES-1:0]      strb;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req_in, req_q, op;
  logic [LANES-1:0]      strb_in;
  logic [3:0]            cnt;
  logic                  commit, in_range, err_q;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] old_word, merged;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef RAM_BYTE_WRITE_EN
  assign strb_in = RAM_BYTE_STROBE;
`else
  assign strb_in = '1;
`endif

  assign req_in = '{addr: RAM_ADDR, we: RAM_WRITE_ENABLE, wdata: RAM_WRITE_DATA, strb: strb_in};
  // With zero wait states the array is accessed on the accept edge, before the latch holds anything.
  assign op       = (state == S_IDLE) ? req_in : req_q;
  assign in_range = {1'b0, op.addr} < DEPTH_L;
  assign idx      = op.addr[IDX_W-1:0];
  assign old_word = mem[idx];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign merged[l*8 +: 8] = op.strb[l] ? op.wdata[l*8 +: 8] : old_word[l*8 +: 8];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (RAM_REQ) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    commit = (state_nxt == S_RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST_N && commit && op.we && in_range) mem[idx] <= merged;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      req_q         <= '0;
      cnt           <= '0;
      err_q         <= 1'b0;
      RAM_READ_DATA <= '0;
    end else begin
      if (state == S_IDLE && RAM_REQ) begin
        req_q <= req_in;
        cnt   <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q         <= !in_range;
        RAM_READ_DATA <= !in_range ? '0 : (op.we ? merged : old_word);
      end
    end
  end

  assign RAM_READY = (state == S_RESP);
  assign RAM_ERROR = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: three instances (WAIT_STATES 1/0/3, DEPTH 1024/1024/512)
// checked through an expected-response queue and a reference word model.
module tb_data_ram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int WS  [3] = '{1, 0, 3};
  localparam int DEP [3] = '{1024, 1024, 512};

  logic                rst_n;
  logic [2:0]          req, we, rdy, err;
  logic [2:0][9:0]     addr;
  logic [2:0][31:0]    wd, rd;
`ifdef RAM_BYTE_WRITE_EN
  logic [2:0][3:0]     strb;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_ram_responder #(
      .ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(DEP[g]), .WAIT_STATES(WS[g])
    ) dut (
      .CLK(clk), .RST_N(rst_n), .RAM_REQ(req[g]), .RAM_ADDR(addr[g]),
      .RAM_WRITE_ENABLE(we[g]), .RAM_WRITE_DATA(wd[g]),
`ifdef RAM_BYTE_WRITE_EN
      .RAM_BYTE_STROBE(strb[g]),
`endif
      .RAM_READY(rdy[g]), .RAM_READ_DATA(rd[g]), .RAM_ERROR(err[g])
    );
  end

  typedef struct { logic [31:0] data; logic err; } exp_t;
  exp_t        sb [$];
  logic [31:0] model [int];
  int          passed = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // One request on unit u; lat = negedges after the first posedge until READY is seen.
  task automatic op(input int u, input bit w, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] s, input bit hold, input bit corrupt, input int lat,
                    input string tag);
    exp_t        e;
    int          key, n;
    bit          got;
    logic [31:0] old, m;
    key   = u * 4096 + int'(a);
    e.err = (int'(a) >= DEP[u]);
    e.data = '0;
    if (!e.err) begin
      old = model.exists(key) ? model[key] : 32'hx;
      for (int l = 0; l < 4; l++) m[l*8 +: 8] = s[l] ? d[l*8 +: 8] : old[l*8 +: 8];
      if (w) begin model[key] = m; e.data = m; end
      else e.data = old;
    end
    sb.push_back(e);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wd[u] = d;
`ifdef RAM_BYTE_WRITE_EN
    strb[u] = s;
`endif
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (corrupt && n == 1) begin
        addr[u] = ~a; wd[u] = ~d; we[u] = ~w;
`ifdef RAM_BYTE_WRITE_EN
        strb[u] = ~s;
`endif
      end
      got = rdy[u];
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    e = sb.pop_front();
    chk({tag, ".data"}, rd[u], e.data);
    chk({tag, ".err"}, 32'(err[u]), 32'(e.err));
    if (!hold) begin
      req[u] = 1'b0;
      @(negedge clk);
      chk({tag, ".pulse"}, 32'(rdy[u]), 32'd0);
      chk({tag, ".errlow"}, 32'(err[u]), 32'd0);
      chk({tag, ".held"}, rd[u], e.data);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pulses;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wd = '0;
`ifdef RAM_BYTE_WRITE_EN
    strb = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst%0d.rdy", u), 32'(rdy[u]), 32'd0);
      chk($sformatf("rst%0d.err", u), 32'(err[u]), 32'd0);
      chk($sformatf("rst%0d.rd", u), rd[u], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // WAIT_STATES=1 store then load
    op(0, 1, 10'h005, 32'hDEADBEEF, 4'hF, 0, 0, 2, "t1.st");
    op(0, 0, 10'h005, 32'h0,        4'hF, 0, 0, 2, "t1.ld");

    // WAIT_STATES=0 back-to-back stores with REQ held: READY every 2nd cycle
    op(1, 1, 10'h000, 32'h01010101, 4'hF, 1, 0, 1, "t2.s0");
    op(1, 1, 10'h001, 32'h02020202, 4'hF, 1, 0, 2, "t2.s1");
    op(1, 1, 10'h002, 32'h03030303, 4'hF, 1, 0, 2, "t2.s2");
    op(1, 1, 10'h003, 32'h04040404, 4'hF, 0, 0, 2, "t2.s3");
    for (int i = 0; i < 4; i++)
      op(1, 0, 10'(i), 32'h0, 4'hF, 0, 0, 1, $sformatf("t2.l%0d", i));

    // DEPTH=512 range boundary, no wrap of out-of-range stores
    op(2, 1, 10'h000, 32'h00C0FFEE, 4'hF, 0, 0, 4, "t3.st0");
    op(2, 1, 10'h1FF, 32'hCAFEF00D, 4'hF, 0, 0, 4, "t3.st1ff");
    op(2, 0, 10'h200, 32'h0,        4'hF, 0, 0, 4, "t3.ld200");
    op(2, 1, 10'h200, 32'hFFFFFFFF, 4'hF, 0, 0, 4, "t3.st200");
    op(2, 1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 0, 0, 4, "t3.st3ff");
    op(2, 0, 10'h1FF, 32'h0,        4'hF, 0, 0, 4, "t3.ld1ff");
    op(2, 0, 10'h000, 32'h0,        4'hF, 0, 0, 4, "t3.ld0");

    // reset during the second WAIT cycle aborts the store
    op(2, 1, 10'h010, 32'h0BADF00D, 4'hF, 0, 0, 4, "t4.pre");
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 10'h010; wd[2] = 32'h12345678;
`ifdef RAM_BYTE_WRITE_EN
    strb[2] = 4'hF;
`endif
    @(posedge clk);
    @(negedge clk);
    chk("t4.w1rdy", 32'(rdy[2]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; req[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4.rst.rdy", 32'(rdy[2]), 32'd0);
    chk("t4.rst.err", 32'(err[2]), 32'd0);
    chk("t4.rst.rd", rd[2], 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[2]) pulses++;
    end
    chk("t4.nopulse", 32'(pulses), 32'd0);
    op(2, 0, 10'h010, 32'h0, 4'hF, 0, 0, 4, "t4.ld");

    // inputs changed after acceptance must be ignored
    op(0, 1, 10'h031, 32'h31313131, 4'hF, 0, 0, 2, "t5.pre");
    op(0, 1, 10'h030, 32'h55AA55AA, 4'hF, 0, 1, 2, "t5.st");
    op(0, 0, 10'h030, 32'h0,        4'hF, 0, 1, 2, "t5.ld30");
    op(0, 0, 10'h031, 32'h0,        4'hF, 0, 0, 2, "t5.ld31");

`ifdef RAM_BYTE_WRITE_EN
    op(0, 1, 10'h020, 32'hAABBCCDD, 4'hF, 0, 0, 2, "t6.full");
    op(0, 1, 10'h020, 32'h11223344, 4'b0101, 0, 0, 2, "t6.merge");
    chk("t6.const", rd[0], 32'hAA22CC44);
    op(0, 1, 10'h020, 32'h99999999, 4'b0000, 0, 0, 2, "t6.none");
    op(0, 0, 10'h020, 32'h0,        4'hF, 0, 0, 2, "t6.ld");
`endif

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
